// File: rtl/if_id_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry circular queue of
// {pc, inst, pred} with independent valid/ready handshakes and a one-cycle flush.
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic              if_pred,
    output logic              if_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_pred,
    input  logic              id_ready,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ZERO_PTR = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic              r_pred_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Ready/valid depend only on the registered count, never on the handshake inputs.
    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == ZERO_CNT);
    assign if_ready = ~w_full;
    assign id_valid = ~w_empty;
    assign count    = r_count;

    assign w_push = rdy & if_valid & ~w_full & ~flush;
    assign w_pop  = rdy & ~w_empty & id_ready & ~flush;

    // Pointer and occupancy update; flush beats push/pop, rdy=0 freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= ZERO_PTR;
            r_tail  <= ZERO_PTR;
            r_count <= ZERO_CNT;
        end else if (rdy && flush) begin
            r_head  <= ZERO_PTR;
            r_tail  <= ZERO_PTR;
            r_count <= ZERO_CNT;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + ONE_PTR;
            end
            if (w_pop) begin
                r_head <= r_head + ONE_PTR;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_pc_mem[r_tail]   <= if_pc;
            r_inst_mem[r_tail] <= if_inst;
            r_pred_mem[r_tail] <= if_pred;
        end
    end

    // Head slot drives decode, replaced by a zero bubble when nothing is queued.
    always_comb begin
        id_pc   = {ADDR_W{1'b0}};
        id_inst = {INST_W{1'b0}};
        id_pred = 1'b0;
        if (w_empty) begin
            id_pc   = {ADDR_W{1'b0}};
            id_inst = {INST_W{1'b0}};
            id_pred = 1'b0;
        end else begin
            id_pc   = r_pc_mem[r_head];
            id_inst = r_inst_mem[r_head];
            id_pred = r_pred_mem[r_head];
        end
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction buffer between fetch (IF) and decode (ID), replacing the single-entry IF/ID register. It holds up to DEPTH fetched instructions with their PC and branch-prediction bit, so that fetch can run ahead while decode is stalled. Fetch and decode talk to it through independent valid/ready handshakes. A misprediction flush empties it in one cycle. Outputs present a zero bubble (PC 0, instruction 0, prediction false) whenever no entry is valid.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst_n  input  1  synchronous, active-low reset
- rdy  input  1  global enable; when 0, all state holds
- flush  input  1  misprediction flush; discards all entries
- if_valid  input  1  IF offers an entry this cycle
- if_pc  input  ADDR_W  PC of offered instruction
- if_inst  input  INST_W  offered instruction
- if_pred  input  1  predicted-taken bit of offered instruction
- if_ready  output  1  queue accepts an entry this cycle
- id_valid  output  1  head entry is valid
- id_pc  output  ADDR_W  head PC, or 0 when empty
- id_inst  output  INST_W  head instruction, or 0 when empty
- id_pred  output  1  head prediction bit, or 0 when empty
- id_ready  input  1  ID consumes the head this cycle
- count  output  CNT_W  current occupancy, 0..DEPTH

## Operation

- Storage is a circular buffer with DEPTH slots.
  - Head pointer and tail pointer are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - The count register is separate from the pointers.
- Handshake conditions:
  - push = rdy & if_valid & if_ready & !flush
  - pop = rdy & id_valid & id_ready & !flush
- if_ready = (count != DEPTH); it is combinational from registered state only.
- id_valid = (count != 0).
- id_pc, id_inst and id_pred come from the head slot, forced to 0 when count == 0.
- On push:
  - write {if_pc, if_inst, if_pred} to the tail slot;
  - tail ← tail+1.
- On pop: head ← head+1.
- Count update:
  - push only: count+1
  - pop only: count−1
  - both: count unchanged
  - neither: count unchanged
- Flush has priority over push and pop in the same cycle. When rdy=1 and flush=1:
  - head ← 0, tail ← 0, count ← 0;
  - the offered IF entry is dropped.
- When rdy=0, pointers, count and storage hold.
  - flush, push and pop are all ignored.
  - Upstream holds flush until rdy returns.
- Full queue:
  - if_ready=0 even if a pop occurs in the same cycle (no full-bypass).
  - The entry is accepted on the next cycle.
- Empty queue: there is no write-through bypass. An entry pushed into an empty queue appears on the ID outputs the cycle after the push.
- Reset (rst_n=0 at posedge, rst_n dominates rdy and flush):
  - head=0, tail=0, count=0;
  - therefore id_valid=0, id_pc=0, id_inst=0, id_pred=0, if_ready=1.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all entries exactly like flush.

## Timing

- Push-to-visible latency: 1 cycle.
- Pop: the head advances at the posedge. The next entry (or a bubble) is visible in the same cycle after that edge.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- Flush takes effect at the posedge of the asserting cycle. In the following cycle:
  - id_valid=0;
  - if_ready=1;
  - a new push is accepted if offered.
- No combinational path from if_valid to if_ready or id_valid.
- No combinational path from id_ready to if_ready.
- Pointer wrap: the slot after DEPTH−1 is slot 0, with no bubble inserted.

## Test plan

- Reset, then hold idle: after rst_n=0 for 1 cycle, count=0, id_valid=0, id_pc=0, id_inst=0, id_pred=0, if_ready=1.
- Fill to full (DEPTH=4) with id_ready=0:
  - push PCs 0x00, 0x04, 0x08, 0x0C with inst 0x00000013 and pred=0,1,0,1;
  - then count=4 and if_ready=0;
  - a fifth if_valid is not accepted.
  - Then id_ready=1 for 4 cycles: id_pc reads 0x00, 0x04, 0x08, 0x0C with id_pred 0,1,0,1, then id_valid=0.
- Sustained streaming: if_valid=id_ready=1 for 20 cycles with PC incrementing by 4.
  - Each PC emerges exactly once, in order.
  - Count stays at 1 after the first cycle.
  - Pointers wrap at least four times.
- Flush collision: with count=3, assert flush together with a push (PC 0x40) and a pop.
  - Next cycle: count=0, id_valid=0.
  - PC 0x40 never appears on id_pc.
- rdy gating: with count=2, drive rdy=0 with if_valid=1, id_ready=1 and flush=1 for 3 cycles.
  - Count stays 2 and the head entry is unchanged.
  - After rdy=1 with flush=0, draining proceeds from the original head.
- Full with simultaneous pop: with count=4, if_valid=1 and id_ready=1.
  - Cycle 1: pop only, count=3.
  - Cycle 2: push and pop both occur, count stays 3, and the new PC appears at the tail position in the drain order.
